// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM states,
// the default operand width and the bit-counter width helper.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Bit counter width for a WIDTH-bit operation; never narrower than 1.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder: the one shared arithmetic cell that the
// sequencer reuses once per operand bit.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two operands and a carry-in on an
// accepted start, feeds them LSB first through one shared full-adder cell,
// and publishes {cout,sum} with a one-cycle done pulse.
module serial_add_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             bit_s;
    logic             bit_c;

    fa_cell u_fa_cell (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; start only matters in IDLE, and
    // busy/done come from the registered state so inputs never reach outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-bit shifting and result publication; sum/cout
    // only move on the final RUN edge so partial results stay hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= {1'b0, op_a[WIDTH-1:1]};
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    res   <= {bit_s, res[WIDTH-1:1]};
                    carry <= bit_c;
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        sum  <= {bit_s, res[WIDTH-1:1]};
                        cout <= bit_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against a plain
// arithmetic reference: {cout,sum} = a + b + cin, done WIDTH+1 cycles
// after the accepting edge.
module tb_serial_add_ctrl;

    localparam int W       = 8;
    localparam int LAT     = W + 1;
    localparam int PERIOD  = W + 2;
    localparam int TIMEOUT = 50;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_tests;
    int n_fail;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Issue one start from IDLE and wait (bounded) for done; lat is the
    // cycle index in which done was seen (cycle 1 follows the start edge).
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         output logic [W-1:0] os, output logic oc, output int lat);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        os = sum;
        oc = cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, cout, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum);
        end
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'h3C;
        repeat (3) tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_holds_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        int busy_cycles;
        int done_cycle;
        int done_count;
        a     = 8'h5A;
        b     = 8'h33;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        done_cycle  = -1;
        done_count  = 0;
        for (int k = 1; k <= 15; k++) begin
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                done_count++;
                done_cycle = k;
                n_tests++;
                if ({cout, sum} !== 9'h08D) begin
                    n_fail++;
                    $display("FAIL basic_result: got cout=%b sum=%h, want cout=0 sum=8d", cout, sum);
                end
            end
            tick();
        end
        n_tests++;
        if (done_cycle != LAT) begin
            n_fail++;
            $display("FAIL basic_latency: got done at cycle %0d, want %0d", done_cycle, LAT);
        end
        n_tests++;
        if (busy_cycles != LAT) begin
            n_fail++;
            $display("FAIL basic_busy_len: got %0d busy cycles, want %0d", busy_cycles, LAT);
        end
        n_tests++;
        if (done_count != 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d, want 1", done_count);
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] s;
        logic         c;
        int           lat;
        do_op(8'hFF, 8'h01, 1'b0, s, c, lat);
        n_tests++;
        if ({c, s} !== 9'h100 || lat != LAT) begin
            n_fail++;
            $display("FAIL carry_ff_01: got cout=%b sum=%h lat=%0d, want cout=1 sum=00 lat=%0d",
                     c, s, lat, LAT);
        end
        tick();
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            n_tests++;
            if (k < LAT) begin
                if (done !== 1'b0 || {cout, sum} !== 9'h100) begin
                    n_fail++;
                    $display("FAIL carry_held_c%0d: got done=%b cout=%b sum=%h, want done=0 cout=1 sum=00",
                             k, done, cout, sum);
                end
            end else begin
                if (done !== 1'b1 || {cout, sum} !== 9'h1FF) begin
                    n_fail++;
                    $display("FAIL carry_ff_ff_1: got done=%b cout=%b sum=%h, want done=1 cout=1 sum=ff",
                             done, cout, sum);
                end
            end
            tick();
        end
    endtask

    task automatic test_ignored_start();
        int done_count;
        int busy_cycles;
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        done_count  = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3 || k == LAT) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'hAA;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                done_count++;
                n_tests++;
                if ({cout, sum} !== 9'h030) begin
                    n_fail++;
                    $display("FAIL ignored_result: got cout=%b sum=%h, want cout=0 sum=30", cout, sum);
                end
            end
            tick();
        end
        start = 1'b0;
        n_tests++;
        if (done_count != 1) begin
            n_fail++;
            $display("FAIL ignored_done_count: got %0d, want 1", done_count);
        end
        n_tests++;
        if (busy_cycles != LAT) begin
            n_fail++;
            $display("FAIL ignored_busy_len: got %0d, want %0d", busy_cycles, LAT);
        end
        n_tests++;
        if ({cout, sum} !== 9'h030) begin
            n_fail++;
            $display("FAIL ignored_held: got cout=%b sum=%h, want cout=0 sum=30", cout, sum);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s;
        logic         c;
        int           lat;
        int           stray;
        a     = 8'h7F;
        b     = 8'h7F;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, cout, sum} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     busy, done, cout, sum);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1 || busy === 1'b1) stray++;
            tick();
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d busy/done cycles after abort, want 0", stray);
        end
        do_op(8'h01, 8'h02, 1'b0, s, c, lat);
        n_tests++;
        if ({c, s} !== 9'h003 || lat != LAT) begin
            n_fail++;
            $display("FAIL midrun_restart: got cout=%b sum=%h lat=%0d, want cout=0 sum=03 lat=%0d",
                     c, s, lat, LAT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W:0] ops_exp [0:44];
        int         dones;
        for (int k = 0; k < 45; k++) begin
            if (k < 40) begin
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
                start = 1'b1;
                ops_exp[k] = ref_add(a, b, cin);
            end else begin
                start = 1'b0;
                ops_exp[k] = '0;
            end
            tick();
            // observed cycle is k+1; a done here answers the edge LAT cycles back
            if (done === 1'b1) begin
                dones++;
                n_tests++;
                if ((k + 1) % PERIOD != LAT || (k + 1) - LAT < 0) begin
                    n_fail++;
                    $display("FAIL b2b_period: got done at cycle %0d, want cycles 9,19,29,39", k + 1);
                end else if ({cout, sum} !== ops_exp[(k + 1) - LAT]) begin
                    n_fail++;
                    $display("FAIL b2b_result: got %h at cycle %0d, want %h", {cout, sum}, k + 1,
                             ops_exp[(k + 1) - LAT]);
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (dones != 4) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d, want 4", dones);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] s;
        logic         c;
        int           lat;
        int           gap;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, s, c, lat);
            n_tests++;
            if ({c, s} !== ref_add(ra, rb, rc) || lat != LAT) begin
                n_fail++;
                $display("FAIL rand_%0d: a=%h b=%h cin=%b got %h lat=%0d, want %h lat=%0d",
                         i, ra, rb, rc, {c, s}, lat, ref_add(ra, rb, rc), LAT);
            end
            tick();
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_done_width_%0d: got done=%b busy=%b after pulse, want 0 0",
                         i, done, busy);
            end
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. It time-shares one single-bit full-adder cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It sits between an operand-issuing requester and the shared adder cell, and owns the start/busy/done handshake. It also owns the operand shift registers, the carry flip-flop and the result registers.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  single rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; sum and cout are valid in that cycle.
- sum  out  WIDTH  result; registered and held until the next completion.
- cout  out  1  final carry; registered and held until the next completion.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; the reset state is IDLE.
- IDLE:
  - start=1 loads a→opA, b→opB and cin→carry.
  - It clears bit counter cnt and goes to RUN.
  - start=0 stays in IDLE.
- RUN, one bit per cycle:
  - The cell computes s, c from opA[0], opB[0], carry.
  - opA and opB shift right by 1, with 0 filled at the MSB.
  - The partial result shifts right, with s inserted at bit WIDTH-1.
  - carry←c; cnt←cnt+1.
- RUN exit: on the cycle with cnt==WIDTH-1, the final bit is processed. On that edge, the completed result goes to sum and c goes to cout, and the FSM moves to DONE.
- DONE:
  - done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- Ignored start:
  - start while busy is ignored. It is not queued and causes no error.
  - start asserted in the DONE cycle is also ignored. The requester must re-assert it in IDLE.
- Held outputs: sum and cout change only on the RUN→DONE edge. Partial results are never visible on the outputs.
- Arithmetic: {cout,sum} = a + b + cin, computed exactly modulo 2^(WIDTH+1). There is no overflow flag.
- cnt width: $clog2(WIDTH). The counter never wraps within an operation because the FSM exits at WIDTH-1.

## Timing
- Reset values, asynchronous on rst_n low: state=IDLE; busy=0; done=0; sum=0; cout=0; carry, cnt, opA, opB and partial result all 0.
- Reset mid-RUN or mid-DONE aborts immediately with no done pulse. The first start after rst_n deasserts is accepted normally.
- Latency:
  - start is sampled high at edge 0.
  - busy is high from edge 0 until the edge 0+WIDTH+1.
  - done and the new sum/cout appear after edge WIDTH, i.e. in cycle WIDTH+1 when edge 0 opens cycle 1.
  - Total: WIDTH+1 cycles from start to done.
- Throughput: one addition per WIDTH+2 cycles with start held high continuously, because one IDLE cycle is required after DONE.
- Outputs busy and done are registered or decoded from the registered state. There is no combinational path from inputs to outputs.

## Structure
- Shared package add_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the WIDTH default constant;
  - a CNT_W function or localparam helper.
- Sub-module fa_cell is a purely combinational 1-bit full adder (a, b, ci → s, co) and is instantiated exactly once. This single instance is the shared resource the controller sequences.
- Everything else (FSM, counter, shift registers, output registers) lives in serial_add_ctrl.

## Test plan
All scenarios use WIDTH=8.
- a=0x5A, b=0x33, cin=0, one-cycle start → done pulses exactly 9 cycles after the start edge; sum=0x8D, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1; prior sum is held until the new done.
- Start 0x10+0x20, then pulse start with a=0xAA at cycles 3 and 9 (the DONE cycle) → both ignored; sum=0x30, cout=0; only one done pulse.
- Start 0x7F+0x7F, assert rst_n=0 at cycle 4 → immediately busy=0, done=0, sum=0, cout=0; no done pulse. After release, 0x01+0x02 → sum=0x03 after 9 cycles.
- start held high for 40 cycles with changing operands → a done pulse every 10 cycles; each result matches the operands present on the accepting IDLE edge.
- Random sweep of 1000 a/b/cin vectors with idle gaps 0..3 → {cout,sum} equals a+b+cin on every done; done is never wider than 1 cycle.
